pipelined_alu: RTL and testbench

PIPELINED_ALU -- requirements
Module: pipelined_alu

---
 rtl/pipelined_alu.sv | 211 +++++++++++++++++++++
 tb/tb_pipelined_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// pipelined_alu
//
// Single-issue ALU with a valid/ready handshake on both sides. Non-shift
// opcodes, reserved opcodes and shifts by zero finish in one cycle. Shifts
// by a non-zero amount run on an iterative shifter. The shifter moves the
// working value by at most SHIFT_STEP bits per cycle, trading latency for a
// small shifter.
//
// Parameters
//   WIDTH       datapath width (power of two, >= 8)
//   RD_W        destination-register index width
//   SHIFT_STEP  maximum shift distance per cycle (power of two, 1..WIDTH)
//
// Ports
//   i_clk       clock, all state on the rising edge
//   i_rst       synchronous active-low reset
//   i_valid     operation offered
//   o_ready     operation accepted when i_valid && o_ready
//   i_flush     abort any in-flight operation and drop a pending result
//   i_function  4-bit opcode
//   i_en        write qualifier, captured at accept
//   i_use_imm   select i_imm instead of i_c as operand C
//   i_b         operand B
//   i_c         operand C
//   i_imm       pre-extended immediate
//   i_rd        destination index
//   o_valid     result available
//   i_ready     consumer takes the result when o_valid && i_ready
//   o_rd        destination of the result
//   o_val       result value
//   o_wr        write request, meaningful only while o_valid

module pipelined_alu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_W       = 6,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    input  logic [3:0]       i_function,
    input  logic             i_en,
    input  logic             i_use_imm,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [RD_W-1:0]  i_rd,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [RD_W-1:0]  o_rd,
    output logic [WIDTH-1:0] o_val,
    output logic             o_wr
);

    localparam int unsigned ShamtW = $clog2(WIDTH);
    localparam int unsigned HalfW  = WIDTH / 2;
    // One extra bit so that SHIFT_STEP == WIDTH is still representable.
    localparam logic [ShamtW:0] StepExt = SHIFT_STEP[ShamtW:0];

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpSlts  = 4'd2;
    localparam logic [3:0] OpSltu  = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpOr    = 4'd5;
    localparam logic [3:0] OpAnd   = 4'd6;
    localparam logic [3:0] OpMove  = 4'd7;
    localparam logic [3:0] OpSmove = 4'd8;
    localparam logic [3:0] OpLsl   = 4'd9;
    localparam logic [3:0] OpLsr   = 4'd10;
    localparam logic [3:0] OpAsr   = 4'd11;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q;

    // Result registers, driven straight onto the outputs.
    logic               valid_q;
    logic [WIDTH-1:0]   val_q;
    logic [RD_W-1:0]    rd_q;
    logic               wr_q;

    // Working registers for a multi-cycle shift.
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   work_q;
    logic [ShamtW-1:0]  rem_q;
    logic [RD_W-1:0]    pend_rd_q;
    logic               pend_en_q;

    // Accept-side decode.
    logic [WIDTH-1:0]   c_sel;
    logic [ShamtW-1:0]  amt;
    logic               is_shift;
    logic               accept;
    logic               start_shift;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_wr;

    // Iterative shifter.
    logic [ShamtW-1:0]  step_amt;
    logic [WIDTH-1:0]   shifted;

    assign c_sel       = i_use_imm ? i_imm : i_c;
    assign amt         = c_sel[ShamtW-1:0];
    assign is_shift    = (i_function == OpLsl) || (i_function == OpLsr) ||
                         (i_function == OpAsr);
    // Including i_rst keeps o_ready low for the whole reset period.
    assign o_ready     = i_rst && (state_q == StIdle) && (!valid_q || i_ready) && !i_flush;
    assign accept      = i_valid && o_ready;
    assign start_shift = accept && is_shift && (amt != '0);

    assign o_valid = valid_q;
    assign o_val   = val_q;
    assign o_rd    = rd_q;
    assign o_wr    = wr_q;

    // Single-cycle result. A shift only reaches this path with amount 0,
    // so it passes B through unchanged.
    always_comb begin
        alu_val = '0;
        case (i_function)
            OpAdd:   alu_val = i_b + c_sel;
            OpSub:   alu_val = i_b - c_sel;
            OpSlts:  alu_val = {{(WIDTH-1){1'b0}}, $signed(i_b) < $signed(c_sel)};
            OpSltu:  alu_val = {{(WIDTH-1){1'b0}}, i_b < c_sel};
            OpXor:   alu_val = i_b ^ c_sel;
            OpOr:    alu_val = i_b | c_sel;
            OpAnd:   alu_val = i_b & c_sel;
            OpMove:  alu_val = c_sel;
            OpSmove: alu_val = {c_sel[HalfW-1:0], i_b[HalfW-1:0]};
            OpLsl,
            OpLsr,
            OpAsr:   alu_val = i_b;
            default: alu_val = '0;
        endcase
    end

    // Opcodes 12-15 never request a write.
    assign alu_wr = i_en && (i_function[3:2] != 2'b11);

    // Shift by min(SHIFT_STEP, remaining). The working value keeps its
    // original sign bit under ASR, so an arithmetic shift of the working
    // value fills with the operand's original sign.
    always_comb begin
        step_amt = ({1'b0, rem_q} < StepExt) ? rem_q : StepExt[ShamtW-1:0];
        case (op_q)
            OpLsl:   shifted = work_q << step_amt;
            OpLsr:   shifted = work_q >> step_amt;
            default: shifted = $unsigned($signed(work_q) >>> step_amt);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            val_q     <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            op_q      <= '0;
            work_q    <= '0;
            rem_q     <= '0;
            pend_rd_q <= '0;
            pend_en_q <= 1'b0;
        end else if (i_flush) begin
            // Working registers are left as they are. They are dead once
            // the state returns to idle.
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_shift) begin
                        // Any earlier result is either absent or being
                        // consumed on this edge, so valid drops.
                        state_q   <= StShift;
                        valid_q   <= 1'b0;
                        op_q      <= i_function;
                        work_q    <= i_b;
                        rem_q     <= amt;
                        pend_rd_q <= i_rd;
                        pend_en_q <= i_en;
                    end else if (accept) begin
                        valid_q <= 1'b1;
                        val_q   <= alu_val;
                        rd_q    <= i_rd;
                        wr_q    <= alu_wr;
                    end else if (i_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                StShift: begin
                    work_q <= shifted;
                    rem_q  <= rem_q - step_amt;
                    // Last step: publish the result on this same edge.
                    if (rem_q == step_amt) begin
                        state_q <= StIdle;
                        valid_q <= 1'b1;
                        val_q   <= shifted;
                        rd_q    <= pend_rd_q;
                        wr_q    <= pend_en_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;

    localparam int WIDTH = 32;
    localparam int RD_W  = 6;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_flush = 1'b0;
    logic [3:0]       i_function = '0;
    logic             i_en = 1'b0;
    logic             i_use_imm = 1'b0;
    logic [WIDTH-1:0] i_b = '0;
    logic [WIDTH-1:0] i_c = '0;
    logic [WIDTH-1:0] i_imm = '0;
    logic [RD_W-1:0]  i_rd = '0;
    logic             i_ready = 1'b0;

    logic             o_ready, o_valid, o_wr;
    logic [RD_W-1:0]  o_rd;
    logic [WIDTH-1:0] o_val;

    logic             o_ready_s1, o_valid_s1, o_wr_s1;
    logic [RD_W-1:0]  o_rd_s1;
    logic [WIDTH-1:0] o_val_s1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(WIDTH), .RD_W(RD_W), .SHIFT_STEP(STEP)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_function(i_function), .i_en(i_en),
        .i_use_imm(i_use_imm), .i_b(i_b), .i_c(i_c), .i_imm(i_imm), .i_rd(i_rd),
        .o_valid(o_valid), .i_ready(i_ready), .o_rd(o_rd), .o_val(o_val), .o_wr(o_wr)
    );

    pipelined_alu #(.WIDTH(WIDTH), .RD_W(RD_W), .SHIFT_STEP(1)) dut_s1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_s1),
        .i_flush(i_flush), .i_function(i_function), .i_en(i_en),
        .i_use_imm(i_use_imm), .i_b(i_b), .i_c(i_c), .i_imm(i_imm), .i_rd(i_rd),
        .o_valid(o_valid_s1), .i_ready(i_ready), .o_rd(o_rd_s1), .o_val(o_val_s1),
        .o_wr(o_wr_s1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: result value straight from the opcode definitions.
    function automatic logic [31:0] ref_val(input logic [3:0] op, input logic [31:0] b,
                                            input logic [31:0] c);
        int unsigned amt;
        amt = c % 32;
        case (op)
            4'd0:  return b + c;
            4'd1:  return b - c;
            4'd2:  return ($signed(b) < $signed(c)) ? 32'd1 : 32'd0;
            4'd3:  return (b < c) ? 32'd1 : 32'd0;
            4'd4:  return b ^ c;
            4'd5:  return b | c;
            4'd6:  return b & c;
            4'd7:  return c;
            4'd8:  return (c << 16) | (b & 32'h0000FFFF);
            4'd9:  return b << amt;
            4'd10: return b >> amt;
            4'd11: return 32'($signed(b) >>> amt);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] c);
        int amt;
        amt = int'(c % 32);
        if (op >= 4'd9 && op <= 4'd11 && amt != 0) return (amt + STEP - 1) / STEP + 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation with i_ready held high, scramble inputs after the
    // accept edge, wait for the result and compare against the model.
    task automatic run_op(input logic [3:0] op, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] imm, input logic use_imm,
                          input logic [RD_W-1:0] rd, input logic en);
        logic [31:0] ce;
        logic [31:0] ev;
        logic        ew;
        int          el;
        int          lat;
        ce = use_imm ? imm : c;
        ev = ref_val(op, b, ce);
        ew = en && (op < 4'd12);
        el = ref_lat(op, ce);
        i_function = op; i_b = b; i_c = c; i_imm = imm; i_use_imm = use_imm;
        i_rd = rd; i_en = en; i_valid = 1'b1; i_ready = 1'b1; i_flush = 1'b0;
        #1;
        check($sformatf("accept_ready op%0d", op), 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        i_b = $urandom; i_c = $urandom; i_imm = $urandom; i_use_imm = 1'($urandom);
        i_function = 4'($urandom); i_rd = RD_W'($urandom); i_en = 1'($urandom);
        lat = 1;
        while (!o_valid && lat < 80) begin
            check($sformatf("busy_ready op%0d", op), 64'(o_ready), 64'd0);
            tick();
            lat++;
        end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(el));
        check($sformatf("val op%0d b=%h c=%h", op, b, ce), 64'(o_val), 64'(ev));
        check($sformatf("rd op%0d", op), 64'(o_rd), 64'(rd));
        check($sformatf("wr op%0d", op), 64'(o_wr), 64'(ew));
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("drain_valid", 64'(o_valid), 64'd0);
    endtask

    initial begin
        int seen;

        // Reset state.
        rst = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b1;
        #1;
        check("ready_in_reset", 64'(o_ready), 64'd0);
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_val", 64'(o_val), 64'd0);
        check("rst_rd", 64'(o_rd), 64'd0);
        check("rst_wr", 64'(o_wr), 64'd0);
        check("rst_valid_s1", 64'(o_valid_s1), 64'd0);
        check("ready_in_reset2", 64'(o_ready), 64'd0);
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("ready_after_release", 64'(o_ready), 64'd1);

        // Directed operations.
        run_op(4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 6'd5, 1'b1);
        run_op(4'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 6'd1, 1'b1);
        run_op(4'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 6'd2, 1'b1);
        run_op(4'd8, 32'h1234ABCD, 32'hDEADBEEF, 32'h00005678, 1'b1, 6'd3, 1'b1);
        run_op(4'd11, 32'h80000000, 32'd9, 32'd0, 1'b0, 6'd4, 1'b1);
        run_op(4'd9, 32'hCAFEF00D, 32'd0, 32'd0, 1'b0, 6'd6, 1'b1);
        run_op(4'd10, 32'hCAFEF00D, 32'h00000020, 32'd0, 1'b0, 6'd7, 1'b0);
        run_op(4'd9, 32'h00000001, 32'd31, 32'd0, 1'b0, 6'd8, 1'b1);
        run_op(4'd11, 32'h7FFFFFFF, 32'd31, 32'd0, 1'b0, 6'd9, 1'b1);
        run_op(4'd13, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, 6'd10, 1'b1);
        drain();

        // Backpressure: result must hold while the consumer stalls, and a
        // new operation offered during the stall must not be taken.
        i_function = 4'd0; i_b = 32'd100; i_c = 32'd23; i_use_imm = 1'b0;
        i_rd = 6'd7; i_en = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
        #1;
        check("bp_ready_empty", 64'(o_ready), 64'd1);
        tick();
        i_function = 4'd1; i_b = 32'd5; i_c = 32'd3; i_rd = 6'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_valid", 64'(o_valid), 64'd1);
            check("bp_val", 64'(o_val), 64'd123);
            check("bp_rd", 64'(o_rd), 64'd7);
            check("bp_ready", 64'(o_ready), 64'd0);
            tick();
        end
        check("bp_val_end", 64'(o_val), 64'd123);
        i_ready = 1'b1;
        #1;
        check("bp_ready_release", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        check("b2b_valid", 64'(o_valid), 64'd1);
        check("b2b_val", 64'(o_val), 64'd2);
        check("b2b_rd", 64'(o_rd), 64'd9);
        drain();

        // Randomized operations, issued back to back.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] cv;
            op = 4'($urandom_range(0, 15));
            cv = $urandom;
            if ($urandom_range(0, 3) == 0) cv = cv & 32'h7;
            run_op(op, $urandom, cv, $urandom, 1'($urandom), RD_W'($urandom), 1'($urandom));
        end
        drain();

        // Flush mid-shift, then reset mid-shift, on both step sizes.
        for (int mode = 0; mode < 2; mode++) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            i_function = 4'd10; i_b = $urandom | 32'h80000000; i_c = 32'd20;
            i_use_imm = 1'b0; i_rd = 6'd33; i_en = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
            #1;
            check("abort_accept", 64'(o_ready), 64'd1);
            check("abort_accept_s1", 64'(o_ready_s1), 64'd1);
            tick();
            i_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("abort_busy", 64'(o_valid), 64'd0);
            check("abort_busy_s1", 64'(o_valid_s1), 64'd0);
            if (mode == 0) begin
                i_flush = 1'b1;
                #1;
                check("flush_ready", 64'(o_ready), 64'd0);
                tick();
                i_flush = 1'b0;
                #1;
                check("flush_valid", 64'(o_valid), 64'd0);
                check("flush_valid_s1", 64'(o_valid_s1), 64'd0);
                check("flush_ready_after", 64'(o_ready), 64'd1);
                check("flush_ready_after_s1", 64'(o_ready_s1), 64'd1);
            end else begin
                rst = 1'b0;
                tick();
                check("mrst_valid", 64'(o_valid), 64'd0);
                check("mrst_valid_s1", 64'(o_valid_s1), 64'd0);
                check("mrst_val_s1", 64'(o_val_s1), 64'd0);
                check("mrst_rd_s1", 64'(o_rd_s1), 64'd0);
                check("mrst_wr_s1", 64'(o_wr_s1), 64'd0);
                rst = 1'b1;
                #1;
                check("mrst_ready_after", 64'(o_ready), 64'd1);
                check("mrst_ready_after_s1", 64'(o_ready_s1), 64'd1);
            end
            seen = 0;
            repeat (30) begin
                tick();
                if (o_valid || o_valid_s1) seen++;
            end
            check("no_stale_result", 64'(seen), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
